counter_seq: RTL and testbench
==============================

COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the width of the counter datapath and command argument.
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port cmd_valid  input  1  command present.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 The block SHALL have port cmd_op  input  2  operation: 00 LOAD, 01 COUNT, 10 NOP, 11 reserved and treated as NOP.
REQ-007 The block SHALL have port cmd_arg  input  WIDTH  load value for LOAD, or step count N for COUNT.
REQ-008 The block SHALL have port abort  input  1  terminates an active COUNT.
REQ-009 The block SHALL have port cnt_en  output  1  counter enable.
REQ-010 The block SHALL have port cnt_load  output  1  counter load strobe.
REQ-011 The block SHALL have port cnt_data  output  WIDTH  counter load value.
REQ-012 The block SHALL have port cnt_value  input  WIDTH  current counter output.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle command-completion pulse.
REQ-015 The block SHALL have port aborted  output  1  valid while done=1; 1 = COUNT ended by abort.
REQ-016 The block SHALL have port wrapped  output  1  one-cycle pulse on a counter wrap.

Function
REQ-017 The block SHALL implement a Moore FSM with states IDLE, LOAD, COUNT and DONE; all outputs SHALL be decoded from registered state only.
REQ-018 In IDLE the block SHALL drive cmd_ready=1; in every other state it SHALL drive cmd_ready=0.
REQ-019 On acceptance, the block SHALL latch cmd_arg into an internal arg register and SHALL latch N into a WIDTH-bit remaining register.
REQ-020 On acceptance, the next state SHALL be: LOAD for op LOAD; COUNT for op COUNT with N!=0; DONE for op COUNT with N==0; DONE for op NOP or reserved.
REQ-021 LOAD SHALL last exactly 1 cycle with cnt_en=1, cnt_load=1 and cnt_data=latched arg, then go to DONE.
REQ-022 COUNT SHALL drive cnt_en=1 and cnt_load=0, and SHALL decrement remaining on each cycle.
REQ-023 COUNT SHALL exit to DONE at the edge where remaining==1, giving exactly N enabled cycles.
REQ-024 Outside LOAD and COUNT, the block SHALL drive cnt_en=0 and cnt_load=0.
REQ-025 cnt_data SHALL equal the latched arg at all times.
REQ-026 If abort=1 at an edge while in COUNT, the next state SHALL be DONE and aborted SHALL be set.
REQ-027 Under REQ-026, the COUNT cycle coincident with abort SHALL still count as enabled.
REQ-028 If abort coincides with remaining==1, the block SHALL treat it as an abort (aborted=1).
REQ-029 abort outside COUNT SHALL be ignored.
REQ-030 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-031 aborted SHALL be cleared on every command acceptance.
REQ-032 wrapped SHALL be 1 in any COUNT cycle where cnt_value is all-ones, i.e. the counter wraps to 0 at that edge.
REQ-033 Latency SHALL be: LOAD accepted at edge k -> done=1 in the cycle after edge k+1; COUNT N>=1 -> done in the cycle after edge k+N; NOP or N=0 -> done in the cycle after edge k.
REQ-034 Minimum spacing between back-to-back commands SHALL be: accept, LOAD or COUNT, DONE, IDLE.

Reset
REQ-035 While rst=1, the block SHALL force state=IDLE, arg=0, remaining=0 and aborted=0, independent of clk.
REQ-036 Consequently, during reset cmd_ready=1, busy=0, done=0, cnt_en=0, cnt_load=0, cnt_data=0 and wrapped=0.
REQ-037 Reset asserted mid-COUNT or mid-LOAD SHALL drop cnt_en immediately, and no done pulse SHALL follow.

Configuration
REQ-038 When macro COUNTER_SEQ_IRQ_EN is defined, the block SHALL add ports irq  output  1  and irq_clr  input  1.
REQ-039 With COUNTER_SEQ_IRQ_EN, irq SHALL set on any cycle with done=1 and SHALL clear on irq_clr=1 at an edge.
REQ-040 With COUNTER_SEQ_IRQ_EN, a simultaneous set and clear SHALL leave irq=1; reset SHALL force irq=0.
REQ-041 Without COUNTER_SEQ_IRQ_EN, the irq and irq_clr ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-042 The bench SHALL apply LOAD with arg=4'hA -> one cycle cnt_en=1, cnt_load=1, cnt_data=A; done one cycle later; aborted=0.
REQ-043 The bench SHALL apply COUNT with arg=3 after LOAD 4'h2 -> cnt_en=1 for exactly 3 cycles; counter model reads 5; done follows.
REQ-044 The bench SHALL apply COUNT with arg=4 after LOAD 4'hE -> wrapped pulses once, in the cycle with cnt_value=F; final count 2.
REQ-045 The bench SHALL apply COUNT with arg=10 and assert abort in the 3rd COUNT cycle -> exactly 3 enabled cycles; done=1 with aborted=1.
REQ-046 The bench SHALL apply COUNT with arg=0 and NOP -> no cnt_en; done in the cycle after acceptance; cmd_ready low only during DONE.
REQ-047 The bench SHALL assert rst during COUNT with arg=8 -> cnt_en=0 immediately, state IDLE, no done; with COUNTER_SEQ_IRQ_EN, irq=0.

Source files
------------

// File: rtl/counter_seq.sv
// counter_seq: command sequencer driving an external up-counter.
// Accepts LOAD / COUNT / NOP commands over a valid/ready handshake and
// produces the counter enable, load strobe and load value. A COUNT of N
// enables the counter for exactly N cycles unless cut short by abort.
// Optional feature: define COUNTER_SEQ_IRQ_EN to add a sticky completion
// interrupt (irq output, irq_clr input).
module counter_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             abort,
   output logic             cnt_en,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_data,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             busy,
   output logic             done,
   output logic             aborted,
`ifdef COUNTER_SEQ_IRQ_EN
   output logic             irq,
   input  logic             irq_clr,
`endif
   output logic             wrapped
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_COUNT = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LOAD  = 2'b01,
      S_COUNT = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] arg_reg, arg_next;
   logic [WIDTH-1:0] remaining_reg, remaining_next;
   logic             aborted_reg, aborted_next;

   // State and datapath registers; reset forces the idle, cleared condition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         arg_reg       <= '0;
         remaining_reg <= '0;
         aborted_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         arg_reg       <= arg_next;
         remaining_reg <= remaining_next;
         aborted_reg   <= aborted_next;
      end
   end

   // Next-state logic: command decode in IDLE, step countdown and abort in COUNT.
   always_comb begin
      state_next     = state_reg;
      arg_next       = arg_reg;
      remaining_next = remaining_reg;
      aborted_next   = aborted_reg;
      case (state_reg)
         S_IDLE: begin
            if (cmd_valid) begin
               arg_next       = cmd_arg;
               remaining_next = cmd_arg;
               aborted_next   = 1'b0;
               if (cmd_op == OP_LOAD) begin
                  state_next = S_LOAD;
               end else if (cmd_op == OP_COUNT) begin
                  // A zero-step COUNT completes immediately like a NOP.
                  state_next = (cmd_arg != '0) ? S_COUNT : S_DONE;
               end else begin
                  state_next = S_DONE;
               end
            end
         end
         S_LOAD: begin
            state_next = S_DONE;
         end
         S_COUNT: begin
            remaining_next = remaining_reg - 1'b1;
            // Abort wins over natural completion so the status reflects it.
            if (abort) begin
               state_next   = S_DONE;
               aborted_next = 1'b1;
            end else if (remaining_reg == WIDTH'(1)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      cmd_ready = (state_reg == S_IDLE);
      busy      = (state_reg != S_IDLE);
      cnt_en    = (state_reg == S_LOAD) || (state_reg == S_COUNT);
      cnt_load  = (state_reg == S_LOAD);
      cnt_data  = arg_reg;
      done      = (state_reg == S_DONE);
      aborted   = aborted_reg;
      // The counter rolls over to zero at the end of an enabled all-ones cycle.
      wrapped   = (state_reg == S_COUNT) && (&cnt_value);
   end

`ifdef COUNTER_SEQ_IRQ_EN
   logic irq_reg;

   // Sticky completion interrupt; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_reg <= 1'b0;
      end else if (state_reg == S_DONE) begin
         irq_reg <= 1'b1;
      end else if (irq_clr) begin
         irq_reg <= 1'b0;
      end
   end

   assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: self-checking bench for counter_seq. An external 4-bit
// counter is attached to cnt_en/cnt_load/cnt_data; expected results for each
// command are derived arithmetically from the command and the counter's
// expected starting value.
module tb_counter_seq;

   localparam int W = 4;

   logic         clk       = 1'b0;
   logic         rst       = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op    = 2'b10;
   logic [W-1:0] cmd_arg   = '0;
   logic         abort     = 1'b0;
   logic         cnt_en;
   logic         cnt_load;
   logic [W-1:0] cnt_data;
   logic [W-1:0] cnt_value = '0;
   logic         busy;
   logic         done;
   logic         aborted;
   logic         wrapped;
`ifdef COUNTER_SEQ_IRQ_EN
   logic         irq;
   logic         irq_clr = 1'b0;
`endif

   int n_cmp   = 0;
   int n_mis   = 0;
   int exp_cnt = 0;

   counter_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .abort     (abort),
      .cnt_en    (cnt_en),
      .cnt_load  (cnt_load),
      .cnt_data  (cnt_data),
      .cnt_value (cnt_value),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
`ifdef COUNTER_SEQ_IRQ_EN
      .irq       (irq),
      .irq_clr   (irq_clr),
`endif
      .wrapped   (wrapped)
   );

   always #5 clk = ~clk;

   // The counter being sequenced.
   always @(posedge clk) begin
      if (cnt_load)
         cnt_value <= cnt_data;
      else if (cnt_en)
         cnt_value <= cnt_value + 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one command and check everything it should produce.
   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg,
                          input int abort_at, input logic abort_hold);
      int   start, en_exp, lat_exp, wr_exp;
      int   en_cnt, ld_cnt, wr_cnt, rdy_hi, lat;
      logic ab_exp, ab_obs;
      logic [W-1:0] ld_data, data_obs;
      start   = exp_cnt;
      ab_exp  = (op == 2'b01) && (arg != 0) && (abort_at != 0) && (abort_at <= int'(arg));
      en_exp  = (op == 2'b00) ? 1 : (op == 2'b01) ? (ab_exp ? abort_at : int'(arg)) : 0;
      lat_exp = (op == 2'b00) ? 2 : (op == 2'b01 && arg != 0) ? en_exp + 1 : 1;
      wr_exp  = 0;
      if (op == 2'b01)
         for (int i = 0; i < en_exp; i++)
            if (((start + i) % 16) == 15) wr_exp++;
      en_cnt = 0; ld_cnt = 0; wr_cnt = 0; rdy_hi = 0; lat = 0;
      ab_obs = 1'b0; ld_data = '0; data_obs = '0;

      check("ready_idle", 32'(cmd_ready), 32'(1));
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      abort     = abort_hold;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_arg   = W'($urandom_range(0, 15));
      for (int c = 1; c <= 40; c++) begin
         if (c == 1) check("aborted_cleared", 32'(aborted), 32'(0));
         if (cnt_en)    en_cnt++;
         if (cnt_load) begin ld_cnt++; ld_data = cnt_data; end
         if (wrapped)   wr_cnt++;
         if (cmd_ready) rdy_hi++;
         if (done) begin
            lat      = c;
            ab_obs   = aborted;
            data_obs = cnt_data;
`ifdef COUNTER_SEQ_IRQ_EN
            irq_clr = 1'($urandom_range(0, 1));
`endif
            break;
         end
         if (op == 2'b01 && abort_at != 0 && cnt_en && en_cnt == abort_at)
            abort = 1'b1;
         else
            abort = abort_hold;
         @(posedge clk); #1;
      end
      abort = 1'b0;

      check("done_seen", 32'(lat != 0), 32'(1));
      check("latency", 32'(lat), 32'(lat_exp));
      check("en_cycles", 32'(en_cnt), 32'(en_exp));
      check("load_cycles", 32'(ld_cnt), 32'((op == 2'b00) ? 1 : 0));
      if (op == 2'b00) check("load_data", 32'(ld_data), 32'(arg));
      check("wrap_pulses", 32'(wr_cnt), 32'(wr_exp));
      check("ready_busy", 32'(rdy_hi), 32'(0));
      check("aborted_done", 32'(ab_obs), 32'(ab_exp));
      check("data_done", 32'(data_obs), 32'(arg));

      if (op == 2'b00) exp_cnt = int'(arg);
      else             exp_cnt = (start + en_exp) % 16;

      @(posedge clk); #1;
`ifdef COUNTER_SEQ_IRQ_EN
      irq_clr = 1'b0;
      check("irq_set", 32'(irq), 32'(1));
`endif
      check("ready_after", 32'(cmd_ready), 32'(1));
      check("busy_after", 32'(busy), 32'(0));
      check("done_once", 32'(done), 32'(0));
      check("count_value", 32'(cnt_value), 32'(exp_cnt));
`ifdef COUNTER_SEQ_IRQ_EN
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      check("irq_clr", 32'(irq), 32'(0));
`endif
      $display("txn op=%0d arg=%0h abort_at=%0d en=%0d lat=%0d aborted=%0b wraps=%0d cnt=%0h",
               op, arg, abort_at, en_cnt, lat, ab_obs, wr_cnt, cnt_value);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  32'(cmd_ready), 32'(1));
      check({tag, "_busy"},   32'(busy),      32'(0));
      check({tag, "_done"},   32'(done),      32'(0));
      check({tag, "_en"},     32'(cnt_en),    32'(0));
      check({tag, "_load"},   32'(cnt_load),  32'(0));
      check({tag, "_data"},   32'(cnt_data),  32'(0));
      check({tag, "_wrap"},   32'(wrapped),   32'(0));
      check({tag, "_abrt"},   32'(aborted),   32'(0));
`ifdef COUNTER_SEQ_IRQ_EN
      check({tag, "_irq"},    32'(irq),       32'(0));
`endif
   endtask

   initial begin
      logic [1:0]   r_op;
      logic [W-1:0] r_arg;
      int           r_ab;
      logic         r_hold;

      // Power-on reset, checked between clock edges.
      #1 rst = 1'b1;
      #2;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Directed scenarios.
      run_cmd(2'b00, 4'hA, 0, 1'b0);
      run_cmd(2'b00, 4'h2, 0, 1'b0);
      run_cmd(2'b01, 4'd3, 0, 1'b0);
      run_cmd(2'b00, 4'hE, 0, 1'b0);
      run_cmd(2'b01, 4'd4, 0, 1'b0);
      run_cmd(2'b01, 4'd10, 3, 1'b0);
      run_cmd(2'b01, 4'd0, 0, 1'b0);
      run_cmd(2'b10, 4'd7, 0, 1'b0);
      run_cmd(2'b11, 4'd5, 0, 1'b1);
      run_cmd(2'b00, 4'h3, 0, 1'b1);
      run_cmd(2'b01, 4'd5, 5, 1'b0);
      run_cmd(2'b01, 4'd1, 0, 1'b0);

      // Reset in the middle of a COUNT of 8 after two enabled edges.
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_arg   = 4'd8;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("rst_pre_en", 32'(cnt_en), 32'(1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_cnt = (exp_cnt + 2) % 16;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check("rst_no_done", 32'(done), 32'(0));
         check("rst_no_en", 32'(cnt_en), 32'(0));
      end
      check("rst_count", 32'(cnt_value), 32'(exp_cnt));
      $display("txn reset-mid-count cnt=%0h busy=%0b", cnt_value, busy);

      // Randomised commands.
      repeat (25) begin
         r_op  = 2'($urandom_range(0, 3));
         r_arg = W'($urandom_range(0, 15));
         if (r_op == 2'b01) begin
            r_hold = 1'b0;
            r_ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (r_arg == 0) ? 1 : int'(r_arg))) : 0;
         end else begin
            r_hold = 1'($urandom_range(0, 1));
            r_ab   = 0;
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_cmd(r_op, r_arg, r_ab, r_hold);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
